// File: rtl/multisim_loopback_crossbar.sv
// Interrupt crossbar between the multisim push and pull servers: transposes the
// irq matrix and commits each destination word only after it has settled.
module multisim_loopback_crossbar #(
  parameter int NUM_CPUS      = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_CPUS-1:0][DATA_WIDTH-1:0]  i_irq,
  output logic [NUM_CPUS-1:0][DATA_WIDTH-1:0]  o_irq,
  output logic [NUM_CPUS-1:0]                  o_update,
  output logic                                 o_busy
);

  typedef enum logic {STABLE = 1'b0, SETTLING = 1'b1} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES);

  state_t                               state_q [NUM_CPUS];
  state_t                               state_d [NUM_CPUS];
  logic [NUM_CPUS-1:0][DATA_WIDTH-1:0]  r_in;
  logic [NUM_CPUS-1:0][DATA_WIDTH-1:0]  cand;
  logic [NUM_CPUS-1:0][DATA_WIDTH-1:0]  snap_q, snap_d;
  logic [NUM_CPUS-1:0][DATA_WIDTH-1:0]  irq_d;
  logic [NUM_CPUS-1:0][7:0]             cnt_q, cnt_d;
  logic [NUM_CPUS-1:0]                  commit;
  logic [NUM_CPUS-1:0]                  upd_d;
  logic                                 busy_d;
  logic                                 unused_r_in_hi;

  // Transpose: bit j of source i lands on bit i of destination j.
  always_comb begin
    cand = '0;
    for (int unsigned j = 0; j < NUM_CPUS; j++)
      for (int unsigned i = 0; i < NUM_CPUS; i++)
        cand[j][i] = r_in[i][j];
  end

  // Source bits at or above NUM_CPUS have no destination to route to.
  always_comb begin
    unused_r_in_hi = 1'b0;
    for (int unsigned i = 0; i < NUM_CPUS; i++)
      for (int unsigned j = NUM_CPUS; j < DATA_WIDTH; j++)
        unused_r_in_hi = unused_r_in_hi ^ r_in[i][j];
  end

  always_comb begin
    for (int unsigned j = 0; j < NUM_CPUS; j++) begin
      state_d[j] = state_q[j];
      snap_d[j]  = snap_q[j];
      cnt_d[j]   = cnt_q[j];
      commit[j]  = 1'b0;
      case (state_q[j])
        STABLE: begin
          if (cand[j] != o_irq[j]) begin
            if (SETTLE_CYCLES == 1) begin
              commit[j] = 1'b1;
            end else begin
              state_d[j] = SETTLING;
              snap_d[j]  = cand[j];
              cnt_d[j]   = 8'd1;
            end
          end
        end
        SETTLING: begin
          if (cand[j] == o_irq[j]) begin
            state_d[j] = STABLE;
          end else if (cand[j] != snap_q[j]) begin
            snap_d[j] = cand[j];
            cnt_d[j]  = 8'd1;
          end else if (cnt_q[j] + 8'd1 == SETTLE_LAST) begin
            commit[j]  = 1'b1;
            state_d[j] = STABLE;
          end else begin
            cnt_d[j] = cnt_q[j] + 8'd1;
          end
        end
        default: state_d[j] = STABLE;
      endcase
    end
  end

  always_comb begin
    busy_d = 1'b0;
    for (int unsigned j = 0; j < NUM_CPUS; j++) begin
      irq_d[j] = commit[j] ? cand[j] : o_irq[j];
      upd_d[j] = commit[j];
      busy_d   = busy_d | (state_d[j] == SETTLING);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in     <= '0;
      o_irq    <= '0;
      o_update <= '0;
      o_busy   <= 1'b0;
      snap_q   <= '0;
      cnt_q    <= '0;
      for (int unsigned j = 0; j < NUM_CPUS; j++) state_q[j] <= STABLE;
    end else begin
      r_in     <= i_irq;
      o_irq    <= irq_d;
      o_update <= upd_d;
      o_busy   <= busy_d;
      snap_q   <= snap_d;
      cnt_q    <= cnt_d;
      for (int unsigned j = 0; j < NUM_CPUS; j++) state_q[j] <= state_d[j];
    end
  end

endmodule

// File: tb/tb_multisim_loopback_crossbar.sv
// Directed bench for multisim_loopback_crossbar: expected commits are queued
// when stimulus changes and matched against every o_update pulse.
module tb_multisim_loopback_crossbar;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int S  = 4;

  typedef logic [N-1:0][DW-1:0] mat_t;

  typedef struct {
    int           cyc;
    logic [N-1:0] upd;
    mat_t         irq;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  mat_t         i_irq;
  mat_t         o_irq;
  logic [N-1:0] o_update;
  logic         o_busy;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  multisim_loopback_crossbar #(
    .NUM_CPUS(N),
    .DATA_WIDTH(DW),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_irq(i_irq),
    .o_irq(o_irq),
    .o_update(o_update),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic mat_t transpose(input mat_t m);
    mat_t t = '0;
    for (int j = 0; j < N; j++)
      for (int i = 0; i < N; i++)
        t[j][i] = m[i][j];
    return t;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h at cyc %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Commit sampled E0 at the next edge lands SETTLE_CYCLES edges later.
  task automatic expect_commit(input logic [N-1:0] upd);
    exp_t e;
    e.cyc = cyc + 1 + S;
    e.upd = upd;
    e.irq = transpose(i_irq);
    sb.push_back(e);
  endtask

  // Every cycle: either the queued pulse is due, or o_update must be quiet.
  always @(negedge clk) begin
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      check("commit_update", 128'(o_update), 128'(sb[0].upd));
      check("commit_irq", 128'(o_irq), 128'(sb[0].irq));
      void'(sb.pop_front());
    end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
      check("missed_commit", 128'(sb[0].cyc), 128'(cyc));
      void'(sb.pop_front());
    end else begin
      check("no_pulse", 128'(o_update), 128'(0));
    end
  end

  initial begin
    rst_n = 1'b0;
    i_irq = '0;
    i_irq[0] = 32'h4;
    tick(3);
    check("reset_irq", 128'(o_irq), 128'(0));
    check("reset_update", 128'(o_update), 128'(0));
    check("reset_busy", 128'(o_busy), 128'(0));

    rst_n = 1'b1;
    expect_commit(4'b0100);
    tick(2);
    check("settle_busy", 128'(o_busy), 128'(1));
    tick(6);
    check("reset_release_irq2", 128'(o_irq[2]), 128'(1));
    check("idle_busy", 128'(o_busy), 128'(0));

    // Glitch shorter than the settle window never commits.
    i_irq[1] = 32'h1;
    tick(2);
    check("glitch_busy_a", 128'(o_busy), 128'(1));
    i_irq[1] = '0;
    tick(1);
    check("glitch_busy_b", 128'(o_busy), 128'(1));
    tick(1);
    check("glitch_busy_c", 128'(o_busy), 128'(0));
    tick(4);
    check("glitch_irq0", 128'(o_irq[0]), 128'(0));

    // Second source joins mid-settle: single commit straight to 0xC.
    i_irq[3] = 32'h2;
    tick(2);
    i_irq[2] = 32'h2;
    expect_commit(4'b0010);
    tick(8);
    check("restart_irq1", 128'(o_irq[1]), 128'hC);

    i_irq = '0;
    expect_commit(4'b0110);
    tick(8);
    check("cleared_irq", 128'(o_irq), 128'(0));

    i_irq[0] = 32'hF;
    expect_commit(4'b1111);
    tick(8);
    for (int j = 0; j < N; j++) check("broadcast_irq", 128'(o_irq[j]), 128'(1));

    i_irq[0] = '0;
    expect_commit(4'b1111);
    tick(8);
    check("broadcast_clear", 128'(o_irq), 128'(0));

    i_irq[0] = 32'hFFFF_FFF0;
    tick(2);
    check("ignored_busy", 128'(o_busy), 128'(0));
    tick(6);
    check("ignored_irq", 128'(o_irq), 128'(0));
    i_irq[0] = '0;
    tick(2);

    // Reset at cnt=2 discards the pending value; re-settle from scratch.
    i_irq[2] = 32'h1;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    check("midreset_irq", 128'(o_irq), 128'(0));
    check("midreset_busy", 128'(o_busy), 128'(0));
    check("midreset_update", 128'(o_update), 128'(0));
    rst_n = 1'b1;
    expect_commit(4'b0001);
    tick(4);
    check("midreset_no_early", 128'(o_irq[0]), 128'(0));
    tick(4);
    check("midreset_irq0", 128'(o_irq[0]), 128'h4);

    check("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multisim_loopback_crossbar.md
Name: multisim_loopback_crossbar

Overview:
- Server-side counterpart to the per-CPU multisim client. It sits in the top/server simulation, between the quasi-static push servers (cpu_to_loopback_N) and the pull servers (loopback_to_cpu_N).
- Routes interrupts between CPUs: the transpose of the irq matrix, so bit j of CPU i's irq_tx becomes bit i of CPU j's irq_rx.
- Quasi-static values cross simulator boundaries with arbitrary skew, so each destination word commits only after its candidate value has been stable for SETTLE_CYCLES samples. This filters transient mixes of old and new values.

Parameters:
- NUM_CPUS, 4, number of CPU clients; legal range 1..DATA_WIDTH.
- DATA_WIDTH, 32, irq word width per CPU.
- SETTLE_CYCLES, 4, consecutive equal samples required before commit; legal range 1..255.

Ports:
- clk  input  1  free-running clock.
- rst_n  input  1  synchronous, active-low reset.
- i_irq  input  [NUM_CPUS-1:0][DATA_WIDTH-1:0]  irq_tx of CPU k at slice k, driven by the push servers.
- o_irq  output  [NUM_CPUS-1:0][DATA_WIDTH-1:0]  irq_rx for CPU k at slice k, feeding the pull servers.
- o_update  output  [NUM_CPUS]  one-cycle pulse; bit j is high on the cycle after o_irq[j] commits a new value.
- o_busy  output  1  high while any destination is in SETTLING.

Behaviour:
- Reset (rst_n low at a clk edge) clears r_in, o_irq, o_update, every snap, and every cnt to 0. Every destination goes to STABLE. Reset mid-settle discards the pending value; nothing commits.
- Input stage: r_in <= i_irq on every edge (1 cycle).
- Candidate for destination j, combinational from r_in:
  - cand[j][i] = r_in[i][j] for i < NUM_CPUS.
  - cand[j][i] = 0 for i >= NUM_CPUS.
  - Input bits j >= NUM_CPUS are ignored.
- Per-destination FSM, independent per j, states STABLE and SETTLING, with snap[j] of DATA_WIDTH bits and cnt[j] of 8 bits:
  - STABLE, cand == o_irq[j]: stay.
  - STABLE, cand != o_irq[j]:
    - If SETTLE_CYCLES == 1: commit on this edge.
    - Otherwise: snap <= cand, cnt <= 1, go to SETTLING.
  - SETTLING, cand == o_irq[j]: abort to STABLE; no update and no pulse.
  - SETTLING, cand != snap (and != o_irq[j]): restart with snap <= cand, cnt <= 1.
  - SETTLING, cand == snap:
    - If cnt+1 == SETTLE_CYCLES: commit.
    - Otherwise: cnt <= cnt+1.
  - Commit: o_irq[j] <= cand, o_update[j] <= 1 for exactly one cycle, go to STABLE.
- o_update is registered and defaults to 0 every cycle unless a commit occurs.
- Latency: a new input value is sampled into r_in at edge E0. After that, cand is first evaluated at edge E1, and o_irq/o_update change at edge E(SETTLE_CYCLES), provided the value stays stable.
- All destinations that see the same input change commit on the same edge.
- o_busy is the registered OR of (state == SETTLING) across all j. It is 0 out of reset.
- No wrap-around: cnt never exceeds SETTLE_CYCLES.

Test Plan:
- Reset: NUM_CPUS=4, SETTLE_CYCLES=4; hold i_irq[0]=0x4 with rst_n low for 3 cycles -> o_irq all 0, o_update=0, o_busy=0. After release, o_irq[2]=0x1 exactly 4 edges after the r_in sample, o_update=4'b0100 for one cycle, other slices 0.
- Glitch: i_irq[1]=0x1 for 2 cycles, then 0 -> o_irq[0] stays 0, no o_update pulse, o_busy high for 2 cycles then low.
- Restart: i_irq[3]=0x2; two cycles later also i_irq[2]=0x2 -> o_irq[1] goes 0 -> 0xC with no intermediate 0x8. The commit comes 4 edges after the second sample, with a single o_update[1] pulse.
- Broadcast: i_irq[0]=0xF -> o_irq[0..3] each become 0x1 on the same edge, o_update=4'b1111 for one cycle. Then i_irq[0]=0 -> all return to 0 with another single 4'b1111 pulse.
- Ignored bits: i_irq[0]=0xFFFF_FFF0 -> o_irq unchanged, no pulse, o_busy stays 0.
- Reset mid-settle: start a change on i_irq[2]=0x1, assert rst_n low at cnt=2 for 1 cycle while holding i_irq -> no commit during reset. After release the FSM re-settles from scratch and commits o_irq[0]=0x4 4 edges after the first post-reset sample.
